// File: rtl/fetch_aligner_if.sv
// Fetch aligner bus: instruction-memory request/response, decode handshake and redirect.
// master = fetch_aligner side, slave = memory/decode/branch side.
interface fetch_aligner_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_compressed_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, is_compressed_o,
    input  mem_rvalid_i, mem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, is_compressed_o,
    output mem_rvalid_i, mem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_aligner.sv
// Fetches 32-bit words and delivers one aligned (32-bit or 16-bit) instruction per handshake.
// FETCH_RVC_EN enables compressed instructions; without it every instruction is 32-bit.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk_i,
  input logic              rst_i,
  fetch_aligner_if.master  bus
);

`ifdef FETCH_RVC_EN
  localparam bit          RvcEn      = 1'b1;
  localparam logic [31:0] ResetPcEff = {RESET_PC[31:1], 1'b0};
  localparam logic        ResetSkip  = RESET_PC[1];
`else
  localparam bit          RvcEn      = 1'b0;
  localparam logic [31:0] ResetPcEff = {RESET_PC[31:2], 2'b00};
  localparam logic        ResetSkip  = 1'b0;
`endif

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] queue_q [4];
  logic [15:0] queue_d [4];
  logic [2:0]  count_q, count_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        skip_q, skip_d;

  logic        compressed;
  logic        valid;
  logic        req;
  logic        push_en;
  logic [2:0]  push_n;
  logic [2:0]  pop_n;
  logic [15:0] push_lo;
  logic [31:0] target;

  // Count gate keeps is_compressed_o low while the queue is empty (incl. reset).
  assign compressed = RvcEn && (count_q != 3'd0) && (queue_q[0][1:0] != 2'b11);
  assign valid      = !bus.redirect_i && (compressed || (count_q >= 3'd2));
  assign req        = !rst_i && (state_q == StReq) && (count_q <= 3'd2) && !bus.redirect_i;
  assign push_en    = (state_q == StWait) && bus.mem_rvalid_i && !bus.redirect_i;
  assign push_n     = skip_q ? 3'd1 : 3'd2;
  assign push_lo    = skip_q ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
  assign pop_n      = (valid && bus.instr_ready_i) ? (compressed ? 3'd1 : 3'd2) : 3'd0;
  assign target     = RvcEn ? {bus.redirect_pc_i[31:1], 1'b0} : {bus.redirect_pc_i[31:2], 2'b00};

  assign bus.mem_req_o       = req;
  assign bus.mem_addr_o      = fetch_addr_q;
  assign bus.instr_valid_o   = valid;
  assign bus.instr_o         = compressed ? {16'h0000, queue_q[0]} : {queue_q[1], queue_q[0]};
  assign bus.instr_pc_o      = pc_q;
  assign bus.is_compressed_o = compressed;

  // Queue: shift out popped halfwords, then append pushed ones behind the survivors.
  always_comb begin
    logic [2:0] idx;
    logic [2:0] base;
    logic [2:0] hi_idx;
    idx    = 3'd0;
    base   = count_q - pop_n;
    hi_idx = base + 3'd1;
    for (int i = 0; i < 4; i++) begin
      queue_d[i] = queue_q[i];
      idx        = 3'(i) + pop_n;
      if (idx < 3'd4) queue_d[i] = queue_q[idx[1:0]];
    end
    count_d = base;
    if (push_en) begin
      queue_d[base[1:0]] = push_lo;
      if (push_n == 3'd2) queue_d[hi_idx[1:0]] = bus.mem_rdata_i[31:16];
      count_d = base + push_n;
    end
    if (bus.redirect_i) count_d = 3'd0;
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    skip_d       = skip_q;

    if (bus.redirect_i) begin
      pc_d         = target;
      fetch_addr_d = {target[31:2], 2'b00};
      skip_d       = RvcEn && bus.redirect_pc_i[1];
    end else begin
      if (pop_n != 3'd0) pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
      if (req)           fetch_addr_d = fetch_addr_q + 32'd4;
      if (push_en)       skip_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (req) state_d = StWait;
      end
      StWait: begin
        if (bus.mem_rvalid_i)    state_d = StReq;
        else if (bus.redirect_i) state_d = StDrop;
      end
      StDrop: begin
        if (bus.mem_rvalid_i) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StReq;
      count_q      <= 3'd0;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      pc_q         <= ResetPcEff;
      skip_q       <= ResetSkip;
      for (int i = 0; i < 4; i++) queue_q[i] <= 16'h0000;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      skip_q       <= skip_d;
      for (int i = 0; i < 4; i++) queue_q[i] <= queue_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a one-outstanding, variable-latency memory model.
module tb_fetch_aligner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_aligner_if bus ();

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          vectors = 0;
  int          errors  = 0;
  int          lat     = 1;
  logic        pend    = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt  = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
`ifdef FETCH_RVC_EN
      32'h0000_0000: return 32'h0013_4501;
      32'h0000_0004: return 32'h4501_0000;
`else
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0000_4501;
`endif
      32'h0000_0008: return 32'h0010_0093;
      32'h0000_000C: return 32'h0020_0113;
      32'h0000_0100: return 32'h0001_4501;
      32'h0000_0104: return 32'h0030_0193;
      32'h0000_0200: return 32'h0040_0213;
      32'hFFFF_FFFC: return 32'h0050_0293;
      default:       return {a[15:0], 16'h0003};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory sees the request pre-edge, answers after `lat` edges.
  task automatic tick();
    logic        req;
    logic [31:0] a;
    #1;
    req = bus.mem_req_o;
    a   = bus.mem_addr_o;
    @(posedge clk);
    #1;
    bus.mem_rvalid_i = 1'b0;
    if (req) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = lat;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = mem_rd(pend_addr);
        pend             = 1'b0;
      end
    end
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                              input logic ec);
    int n = 0;
    bus.instr_ready_i = 1'b1;
    #1;
    while (!bus.instr_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(bus.instr_valid_o), 32'd1);
    chk({tag, ".instr"}, bus.instr_o, ei);
    chk({tag, ".pc"}, bus.instr_pc_o, ep);
    chk({tag, ".is_c"}, 32'(bus.is_compressed_o), 32'(ec));
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    #1;
    while (!bus.mem_req_o && n < 30) begin
      tick();
      n++;
    end
    chk({tag, ".req_seen"}, 32'(bus.mem_req_o), 32'd1);
  endtask

  initial begin
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = 32'h0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    tick();
    tick();

    chk("rst.mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst.mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst.valid", 32'(bus.instr_valid_o), 32'd0);
    chk("rst.instr", bus.instr_o, 32'h0);
    chk("rst.pc", bus.instr_pc_o, 32'h0);
    chk("rst.is_c", 32'(bus.is_compressed_o), 32'd0);

    rst = 1'b0;
    #1;
    chk("first.req", 32'(bus.mem_req_o), 32'd1);
    chk("first.addr", bus.mem_addr_o, 32'h0);

`ifdef FETCH_RVC_EN
    expect_instr("rvc.pc0", 32'h0000_4501, 32'h0, 1'b1);
    expect_instr("rvc.pc2", 32'h0000_0013, 32'h2, 1'b0);
    expect_instr("rvc.pc6", 32'h0000_4501, 32'h6, 1'b1);
`else
    expect_instr("w32.pc0", 32'h0000_0013, 32'h0, 1'b0);
    expect_instr("w32.pc4", 32'h0000_4501, 32'h4, 1'b0);
`endif

    // Stall with decode not ready: output frozen, fetching stops once the queue is full.
    bus.instr_ready_i = 1'b0;
    for (int n = 0; n < 20 && !bus.instr_valid_o; n++) tick();
    for (int s = 0; s < 5; s++) begin
      chk("stall.valid", 32'(bus.instr_valid_o), 32'd1);
      chk("stall.instr", bus.instr_o, 32'h0010_0093);
      chk("stall.pc", bus.instr_pc_o, 32'h8);
      tick();
    end
    chk("stall.no_req", 32'(bus.mem_req_o), 32'd0);
    expect_instr("stall.pc8", 32'h0010_0093, 32'h8, 1'b0);
    expect_instr("stall.pcC", 32'h0020_0113, 32'hC, 1'b0);
    expect_instr("stall.pc10", 32'h0010_0003, 32'h10, 1'b0);

    // Redirect while a request is outstanding: stale word must be dropped.
    lat = 3;
    wait_req("rd.pre");
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    #1;
    chk("rd.no_req", 32'(bus.mem_req_o), 32'd0);
    chk("rd.no_valid", 32'(bus.instr_valid_o), 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    wait_req("rd.post");
    chk("rd.addr", bus.mem_addr_o, 32'h0000_0100);
`ifdef FETCH_RVC_EN
    expect_instr("rd.first", 32'h0000_0001, 32'h0000_0102, 1'b1);
`else
    expect_instr("rd.first", 32'h0001_4501, 32'h0000_0100, 1'b0);
`endif

    // Redirect, response and decode-ready in the same cycle.
    lat = 2;
    bus.instr_ready_i = 1'b0;
    begin
      int n = 0;
      #1;
      while (!(bus.mem_rvalid_i && bus.instr_valid_o) && n < 40) begin
        tick();
        n++;
      end
      chk("same.coincide", 32'(bus.mem_rvalid_i && bus.instr_valid_o), 32'd1);
    end
    bus.instr_ready_i = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    #1;
    chk("same.valid_masked", 32'(bus.instr_valid_o), 32'd0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("same.pc", bus.instr_pc_o, 32'h0000_0200);
    chk("same.empty", 32'(bus.instr_valid_o), 32'd0);
    expect_instr("same.first", 32'h0040_0213, 32'h0000_0200, 1'b0);

    // Back-to-back redirects: the later target wins.
    lat = 1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0300;
    tick();
    bus.redirect_pc_i = 32'h0000_0104;
    tick();
    bus.redirect_i = 1'b0;
    expect_instr("last.wins", 32'h0030_0193, 32'h0000_0104, 1'b0);

    // Fetch address wraps from the top of memory to zero.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    expect_instr("wrap.top", 32'h0050_0293, 32'hFFFF_FFFC, 1'b0);
`ifdef FETCH_RVC_EN
    expect_instr("wrap.zero", 32'h0000_4501, 32'h0, 1'b1);
`else
    expect_instr("wrap.zero", 32'h0000_0013, 32'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
